// File: rtl/noc_axi4_mem_responder.sv
// AXI4 slave terminating the NoC bridge master port on block RAM instead of DDR4.
// One transaction at a time; a single FSM serialises writes and reads.
module noc_axi4_mem_responder #(
   parameter int ID_WIDTH   = 16,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int MEM_WORDS  = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ID_WIDTH-1:0]       s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [ID_WIDTH-1:0]       s_axi_rid,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_WORDS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_FETCH,
      S_RD_DATA
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   logic [ID_WIDTH-1:0]   r_id;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic                  r_fixed;
   logic                  r_err;
   logic                  r_perr;
   logic                  r_pref_wr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_rlast;

   logic                  w_aw_grant;
   logic                  w_ar_grant;
   logic                  w_awready;
   logic                  w_arready;
   logic                  w_last_beat;
   logic                  w_aw_err;
   logic                  w_ar_err;
   logic                  w_w_fire;
   logic                  w_mem_we;
   logic [IDX_W-1:0]      w_idx_next;
   logic                  w_unused;

   // Any address bit above the word-index field marks the whole burst out of range.
   assign w_aw_err    = |(s_axi_awaddr >> (LSB + IDX_W));
   assign w_ar_err    = |(s_axi_araddr >> (LSB + IDX_W));
   assign w_last_beat = (r_beat == r_len);
   assign w_idx_next  = r_fixed ? r_idx : r_idx + IDX_W'(1);
   assign w_w_fire    = (r_state == S_WR_DATA) && s_axi_wvalid;
   assign w_mem_we    = w_w_fire && !r_err;
   assign w_unused    = ^{s_axi_awsize, s_axi_arsize};

   assign w_aw_grant  = s_axi_awvalid && (r_pref_wr || !s_axi_arvalid);
   assign w_ar_grant  = s_axi_arvalid && (!r_pref_wr || !s_axi_awvalid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_awready   = 1'b0;
      w_arready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rst_n) begin
               if (w_aw_grant) begin
                  w_awready   = 1'b1;
                  w_state_nxt = S_WR_DATA;
               end else if (w_ar_grant) begin
                  w_arready   = 1'b1;
                  w_state_nxt = S_RD_FETCH;
               end
            end
         end
         S_WR_DATA:  if (s_axi_wvalid && w_last_beat) w_state_nxt = S_WR_RESP;
         S_WR_RESP:  if (s_axi_bready) w_state_nxt = S_IDLE;
         S_RD_FETCH: w_state_nxt = S_RD_DATA;
         S_RD_DATA:  if (s_axi_rready) w_state_nxt = r_rlast ? S_IDLE : S_RD_FETCH;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id      <= '0;
         r_idx     <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_fixed   <= 1'b0;
         r_err     <= 1'b0;
         r_perr    <= 1'b0;
         r_pref_wr <= 1'b1;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
      end else begin
         if (w_awready) begin
            r_id    <= s_axi_awid;
            r_idx   <= s_axi_awaddr[LSB +: IDX_W];
            r_len   <= s_axi_awlen;
            r_fixed <= (s_axi_awburst == BURST_FIXED);
            r_err   <= w_aw_err;
            r_perr  <= 1'b0;
            r_beat  <= '0;
            if (s_axi_arvalid) r_pref_wr <= 1'b0;
         end else if (w_arready) begin
            r_id    <= s_axi_arid;
            r_idx   <= s_axi_araddr[LSB +: IDX_W];
            r_len   <= s_axi_arlen;
            r_fixed <= (s_axi_arburst == BURST_FIXED);
            r_err   <= w_ar_err;
            r_beat  <= '0;
            if (s_axi_awvalid) r_pref_wr <= 1'b1;
         end

         // awlen is authoritative for the beat count; wlast only flags a protocol error.
         if (w_w_fire) begin
            if (s_axi_wlast != w_last_beat) r_perr <= 1'b1;
            if (!w_last_beat) begin
               r_beat <= r_beat + 8'd1;
               r_idx  <= w_idx_next;
            end
         end

         if (r_state == S_RD_FETCH) begin
            r_rdata <= r_err ? '0 : r_mem[r_idx];
            r_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
            r_rlast <= w_last_beat;
         end

         if ((r_state == S_RD_DATA) && s_axi_rready && !r_rlast) begin
            r_beat <= r_beat + 8'd1;
            r_idx  <= w_idx_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) r_mem[r_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   assign s_axi_awready = w_awready;
   assign s_axi_arready = w_arready;
   assign s_axi_wready  = (r_state == S_WR_DATA);
   assign s_axi_bvalid  = (r_state == S_WR_RESP);
   assign s_axi_bid     = r_id;
   assign s_axi_bresp   = ((r_state == S_WR_RESP) && (r_err || r_perr)) ? RESP_SLVERR : RESP_OKAY;
   assign s_axi_rvalid  = (r_state == S_RD_DATA);
   assign s_axi_rid     = r_id;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_noc_axi4_mem_responder.sv
// Bench for noc_axi4_mem_responder: directed AXI4 scenarios plus randomized bursts
// checked against a word-array memory model.
module tb_noc_axi4_mem_responder;

   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int MW  = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [IDW-1:0]  awid = '0, arid = '0;
   logic [AW-1:0]   awaddr = '0, araddr = '0;
   logic [7:0]      awlen = '0, arlen = '0;
   logic [2:0]      awsize = 3'd3, arsize = 3'd3;
   logic [1:0]      awburst = 2'b01, arburst = 2'b01;
   logic            awvalid = 1'b0, arvalid = 1'b0;
   logic            awready, arready;
   logic [DW-1:0]   wdata = '0;
   logic [DW/8-1:0] wstrb = '0;
   logic            wlast = 1'b0, wvalid = 1'b0, wready;
   logic [IDW-1:0]  bid, rid;
   logic [1:0]      bresp, rresp;
   logic            bvalid, bready = 1'b0;
   logic [DW-1:0]   rdata;
   logic            rlast, rvalid, rready = 1'b0;

   always #5 clk = ~clk;

   noc_axi4_mem_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   int errors = 0;
   int checks = 0;

   logic [63:0] mm [MW];
   logic [63:0] wd [256];
   logic [7:0]  ws [256];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: byte address -> word index, range check, burst addressing.
   function automatic int widx(input logic [31:0] a);
      return int'(a[8:3]);
   endfunction

   function automatic bit oor(input logic [31:0] a);
      return a[31:9] != 23'd0;
   endfunction

   function automatic int bidx(input logic [31:0] a, input int b, input logic [1:0] burst);
      return (burst == 2'b00) ? widx(a) : (widx(a) + b) % MW;
   endfunction

   function automatic bit wl_of(input int b, input int len, input int early);
      return (early >= 0) ? (b == early) : (b == len);
   endfunction

   task automatic model_write(input logic [31:0] a, input int len, input logic [1:0] burst,
                              input int early, output logic [1:0] resp);
      bit perr = 0;
      for (int b = 0; b <= len; b++) begin
         if (wl_of(b, len, early) != (b == len)) perr = 1;
         if (!oor(a)) begin
            for (int k = 0; k < 8; k++)
               if (ws[b][k]) mm[bidx(a, b, burst)][8*k +: 8] = wd[b][8*k +: 8];
         end
      end
      resp = (oor(a) || perr) ? 2'b10 : 2'b00;
   endtask

   task automatic fill_full(input int len);
      for (int b = 0; b <= len; b++) begin
         wd[b] = {$urandom, $urandom};
         ws[b] = 8'hFF;
      end
   endtask

   task automatic aw_phase(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst);
      int t = 0;
      awid = id; awaddr = a; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
      #1;
      while (!awready && t < 20) begin @(negedge clk); #1; t++; end
      chk("aw_ready", awready, 1);
      @(posedge clk); #1 awvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic w_phase(input int len, input int early, input bit stall);
      int t;
      for (int b = 0; b <= len; b++) begin
         if (stall) begin
            wvalid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wdata = wd[b]; wstrb = ws[b]; wlast = wl_of(b, len, early); wvalid = 1'b1;
         #1;
         t = 0;
         while (!wready && t < 20) begin @(negedge clk); #1; t++; end
         chk("w_ready", wready, 1);
         @(posedge clk); @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("b_latency", bvalid, 1);
   endtask

   task automatic b_phase(input logic [3:0] id, input logic [1:0] resp, input int hold);
      int t = 0;
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      chk("b_valid", bvalid, 1);
      chk("b_id", bid, id);
      chk("b_resp", bresp, resp);
      repeat (hold) begin
         @(negedge clk);
         chk("b_hold_valid", bvalid, 1);
         chk("b_hold_id", bid, id);
         chk("b_hold_resp", bresp, resp);
      end
      bready = 1'b1;
      @(posedge clk); #1 bready = 1'b0;
      @(negedge clk);
      chk("b_done", bvalid, 0);
   endtask

   task automatic ar_tail();
      @(negedge clk);
      chk("r_fetch_gap", rvalid, 0);
      @(negedge clk);
      chk("r_first_lat", rvalid, 1);
   endtask

   task automatic ar_phase(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst);
      int t = 0;
      arid = id; araddr = a; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
      #1;
      while (!arready && t < 20) begin @(negedge clk); #1; t++; end
      chk("ar_ready", arready, 1);
      @(posedge clk); #1 arvalid = 1'b0;
      ar_tail();
   endtask

   task automatic r_phase(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc);
      int t;
      logic [63:0] exp;
      for (int b = 0; b <= len; b++) begin
         t = 0;
         while (!rvalid && t < 20) begin @(negedge clk); t++; end
         exp = oor(a) ? 64'd0 : mm[bidx(a, b, burst)];
         chk("r_valid", rvalid, 1);
         chk("r_id", rid, id);
         chk("r_data", rdata, exp);
         chk("r_resp", rresp, oor(a) ? 2'b10 : 2'b00);
         chk("r_last", rlast, (b == len));
         if (b == stall_beat) begin
            repeat (stall_cyc) begin
               @(negedge clk);
               chk("r_hold_valid", rvalid, 1);
               chk("r_hold_data", rdata, exp);
               chk("r_hold_last", rlast, (b == len));
            end
         end
         rready = 1'b1;
         @(posedge clk); #1 rready = 1'b0;
         @(negedge clk);
         chk("r_gap", rvalid, 0);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst,
                           input int early, input int bhold, input bit stall);
      logic [1:0] er;
      model_write(a, len, burst, early, er);
      aw_phase(id, a, len, burst);
      w_phase(len, early, stall);
      b_phase(id, er, bhold);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst,
                          input int sb, input int sc);
      ar_phase(id, a, len, burst);
      r_phase(id, a, len, burst, sb, sc);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_awready"}, awready, 0);
      chk({tag, "_arready"}, arready, 0);
      chk({tag, "_wready"}, wready, 0);
      chk({tag, "_bvalid"}, bvalid, 0);
      chk({tag, "_bid"}, bid, 0);
      chk({tag, "_bresp"}, bresp, 0);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_rid"}, rid, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_rresp"}, rresp, 0);
      chk({tag, "_rlast"}, rlast, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] er1, er2;
      logic [31:0] a;
      int len;
      logic [1:0] burst;

      // Reset: outputs quiet even with requests pending.
      repeat (3) @(negedge clk);
      awvalid = 1'b1; arvalid = 1'b1;
      #1;
      chk_outputs_zero("rst");
      awvalid = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);

      // Basic INCR write then read back.
      for (int b = 0; b < 4; b++) begin wd[b] = 64'hA0 + 64'(b); ws[b] = 8'hFF; end
      do_write(4'd1, 32'h40, 3, 2'b01, -1, 0, 0);
      do_read(4'd2, 32'h40, 3, 2'b01, -1, 0);

      // Simultaneous AW and AR: write, read, write.
      fill_full(1);
      model_write(32'h100, 1, 2'b01, -1, er1);
      awid = 4'd3; awaddr = 32'h100; awlen = 8'd1; awburst = 2'b01; awvalid = 1'b1;
      arid = 4'd4; araddr = 32'h40; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
      #1;
      chk("arb1_awready", awready, 1);
      chk("arb1_arready", arready, 0);
      @(posedge clk); #1 awvalid = 1'b0;
      @(negedge clk);
      w_phase(1, -1, 0);
      b_phase(4'd3, er1, 0);
      fill_full(1);
      model_write(32'h110, 1, 2'b01, -1, er2);
      awid = 4'd5; awaddr = 32'h110; awlen = 8'd1; awvalid = 1'b1;
      #1;
      chk("arb2_arready", arready, 1);
      chk("arb2_awready", awready, 0);
      @(posedge clk); #1 arvalid = 1'b0;
      ar_tail();
      r_phase(4'd4, 32'h40, 3, 2'b01, -1, 0);
      aw_phase(4'd5, 32'h110, 1, 2'b01);
      w_phase(1, -1, 0);
      b_phase(4'd5, er2, 0);
      do_read(4'd6, 32'h100, 3, 2'b01, -1, 0);

      // Backpressure on B and mid-burst on R.
      fill_full(3);
      do_write(4'd6, 32'h180, 3, 2'b01, -1, 5, 0);
      do_read(4'd7, 32'h180, 3, 2'b01, 1, 3);

      // Fill the whole memory so every later read has a defined expectation.
      fill_full(63);
      do_write(4'd0, 32'h0, 63, 2'b01, -1, 0, 0);

      // Out-of-range write/read; word 8 must be untouched.
      fill_full(1);
      do_write(4'd8, 32'h240, 1, 2'b01, -1, 0, 0);
      do_read(4'd9, 32'h240, 1, 2'b01, -1, 0);
      do_read(4'd9, 32'h40, 1, 2'b01, -1, 0);

      // FIXED burst with partial strobes, then early wlast.
      for (int b = 0; b < 3; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'(1 << b); end
      do_write(4'd10, 32'h80, 2, 2'b00, -1, 0, 0);
      do_read(4'd11, 32'h80, 0, 2'b01, -1, 0);
      fill_full(3);
      do_write(4'd12, 32'hC0, 3, 2'b01, 1, 0, 0);
      do_read(4'd13, 32'hC0, 3, 2'b01, -1, 0);

      // Maximum length burst wrapping around the memory.
      fill_full(255);
      do_write(4'd14, 32'h1F0, 255, 2'b01, -1, 0, 0);
      do_read(4'd15, 32'h1F0, 255, 2'b10, -1, 0);

      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         a = 32'($urandom_range(0, 511));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(9, 31));
         len = $urandom_range(0, 7);
         burst = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b <= len; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
            do_write(4'($urandom), a, len, burst, -1, $urandom_range(0, 2), 1'b1);
         end else begin
            do_read(4'($urandom), a, len, burst, $urandom_range(0, 7), $urandom_range(0, 2));
         end
      end

      // Reset in the middle of a write burst.
      fill_full(3);
      aw_phase(4'd1, 32'h100, 3, 2'b01);
      wdata = wd[0]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      wdata = wd[1];
      #1 rst_n = 1'b0; awvalid = 1'b1;
      #1;
      chk_outputs_zero("midrst");
      wvalid = 1'b0; awvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_b", bvalid, 0);
      end
      fill_full(3);
      do_write(4'd2, 32'h100, 3, 2'b01, -1, 0, 0);
      do_read(4'd3, 32'h100, 3, 2'b01, -1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
